riscv_instr_line_buffer: RTL and testbench
==========================================

Name: riscv_instr_line_buffer

Overview:
- Small fully-associative L0 instruction line buffer between the prefetch buffer's instruction port and instruction memory.
- Faces the prefetch buffer with the same req/gnt/rvalid protocol the memory presents.
- Answers hits with one-cycle latency; on a miss, refills a whole line from memory with single-outstanding word requests.
- Cuts memory-latency exposure for sequential and short-loop fetch.

Parameters:
- NUM_LINES, 2, number of lines; power of two, ≥2.
- LINE_WORDS, 4, 32-bit words per line; power of two, ≥2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- instr_req_i  in  1  fetch request from prefetch buffer
- instr_addr_i  in  32  fetch address; bits [1:0] ignored
- instr_gnt_o  out  1  request accepted this cycle
- instr_rvalid_o  out  1  response valid, exactly one cycle after gnt
- instr_rdata_o  out  32  response word
- instr_err_o  out  1  response carries bus error; qualified by rvalid
- flush_i  in  1  invalidate all lines (fence.i)
- mem_req_o  out  1  refill word request
- mem_addr_o  out  32  refill word address, word-aligned
- mem_gnt_i  in  1  memory grant
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  32  memory response data
- mem_err_i  in  1  memory error; qualified by mem_rvalid_i
- busy_o  out  1  refill in progress or response pending

Behaviour:
- Reset (rst_n=0 at clk edge):
  - All lines invalid; FSM=IDLE; word counter and replacement pointer =0; flush_pending=0.
  - Outputs: instr_gnt_o=0, instr_rvalid_o=0, instr_rdata_o=0, instr_err_o=0, mem_req_o=0, mem_addr_o=0, busy_o=0.
  - Reset mid-refill abandons the refill; memory is reset with the core. mem_rvalid_i arriving in IDLE is ignored.
- Line addressing: OFF=log2(LINE_WORDS); tag=addr[31:OFF+2]; word index=addr[OFF+1:2].
- Hit: some valid line has tag==instr_addr_i tag.
- FSM states: IDLE, REFILL_REQ, REFILL_WAIT.
- IDLE:
  - instr_gnt_o = instr_req_i & hit & ~flush_i, combinational.
  - On gnt: the next cycle drives instr_rvalid_o=1, instr_rdata_o=hit word, instr_err_o=0.
  - Back-to-back hits are granted every cycle, so full throughput (gnt in the rvalid cycle is legal).
  - instr_req_i & ~hit & ~flush_i → no gnt. Latch line base = {tag, OFF+2 zero bits}, victim = replacement pointer; go to REFILL_REQ.
- REFILL_REQ:
  - mem_req_o=1, mem_addr_o = base + 4·word counter.
  - mem_gnt_i → REFILL_WAIT; otherwise hold (address stable).
- REFILL_WAIT:
  - On mem_rvalid_i: write the word into the victim line and OR mem_err_i into a sticky line-error flag.
  - If the word counter is not the last word: increment, and in the same cycle assert mem_req_o with the next address (→ REFILL_WAIT on gnt, else REFILL_REQ).
  - Last word: write tag. Set valid = ~line_error & ~flush_pending. Advance the replacement pointer (modulo NUM_LINES). Clear the counter; → IDLE.
  - Victim valid bit is cleared on refill start.
- Error handling:
  - If a refill ends with an error and the core still requests that line in the first IDLE cycle, grant it once.
  - That response carries instr_err_o=1, rdata=0, and the line stays invalid.
  - After that single error response, the error is discarded.
- No grants are issued during REFILL_REQ/REFILL_WAIT. The requester may change instr_addr_i while ungranted (branch/hwloop); the refill always completes and the address is re-evaluated in IDLE.
- flush_i:
  - In IDLE: all valid bits clear next cycle, and gnt is suppressed that cycle.
  - During a refill: set flush_pending. The refilled line completes but is left invalid; flush_pending clears on return to IDLE.
  - A response already granted still returns its data.
- Refill always proceeds word 0..LINE_WORDS-1 (no critical-word-first).
- busy_o = (FSM≠IDLE) | instr_rvalid_o pending.

Test Plan:
- Cold miss: req addr 0x100 → no gnt; 4 mem requests at 0x100, 0x104, 0x108, 0x10C with gnt=1 and 1-cycle rvalid data 0xA0..0xA3; then gnt; rvalid next cycle with rdata=0xA0.
- Sequential hits: after fill, req 0x104, 0x108, 0x10C on consecutive cycles → gnt each cycle; rvalid one cycle later with 0xA1, 0xA2, 0xA3; mem_req_o stays 0.
- Replacement: fill 0x100, 0x200, then 0x300 → 0x300 overwrites the 0x100 line; req 0x100 misses again; req 0x204 hits.
- Address change during refill: miss at 0x100, switch instr_addr_i to 0x400 mid-refill → 0x100 line completes, then refill 0x400..0x40C, then gnt for 0x400.
- Flush during refill: assert flush_i while the word-2 request is outstanding → refill completes, line invalid, req 0x100 re-refills; flush_i with a simultaneous hit req → gnt=0 that cycle.
- Error and reset: mem_err_i=1 on word 1 → one response with instr_err_o=1 and rdata=0, next req re-refills. Separately, rst_n=0 mid-refill → next cycle all outputs 0, all lines invalid.

Source files
------------

// File: rtl/riscv_instr_line_buffer.sv
// riscv_instr_line_buffer
// Small fully-associative L0 instruction line buffer placed between the
// prefetch buffer and instruction memory. Hits are answered with one-cycle
// latency. A miss refills the whole line from memory, one word at a time,
// with a single request outstanding.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   instr_req_i / instr_addr_i       fetch request and address from the prefetcher
//   instr_gnt_o                      request accepted this cycle (combinational)
//   instr_rvalid_o / instr_rdata_o   response one cycle after the grant
//   instr_err_o                      response carries a bus error
//   flush_i                          invalidate all lines (fence.i)
//   mem_req_o / mem_addr_o           refill word request and word address
//   mem_gnt_i                        memory accepted the request
//   mem_rvalid_i / mem_rdata_i       refill word returned by memory
//   mem_err_i                        refill word carries a bus error
//   busy_o                           refill in progress or response pending
module riscv_instr_line_buffer #(
  parameter int NUM_LINES  = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        busy_o
);

  localparam int OFF    = $clog2(LINE_WORDS);
  localparam int LIDX_W = $clog2(NUM_LINES);
  localparam int TAG_W  = 30 - OFF;

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] REFILL_REQ  = 2'd1;
  localparam logic [1:0] REFILL_WAIT = 2'd2;

  logic [1:0]              state_reg;
  logic [NUM_LINES-1:0]    valid_reg;
  logic [TAG_W-1:0]        tag_mem [NUM_LINES];
  logic [31:0]             data_mem [NUM_LINES*LINE_WORDS];
  logic [OFF-1:0]          cnt_reg;
  logic [LIDX_W-1:0]       ptr_reg;
  logic [LIDX_W-1:0]       victim_reg;
  logic [TAG_W-1:0]        refill_tag_reg;
  logic                    line_err_reg;
  logic                    flush_pending_reg;
  logic                    err_pending_reg;
  logic                    rvalid_reg;
  logic                    err_reg;
  logic [31:0]             rdata_reg;

  logic [TAG_W-1:0]        req_tag;
  logic [OFF-1:0]          req_word;
  logic [OFF-1:0]          word_sel;
  logic [NUM_LINES-1:0]    line_hit;
  logic [LIDX_W-1:0]       hit_idx;
  logic [31:0]             rd_word;
  logic                    hit;
  logic                    err_hit;
  logic                    is_idle;
  logic                    gnt_hit;
  logic                    gnt_err;
  logic                    start_refill;
  logic                    wait_word;
  logic                    last_word;
  logic                    line_err_next;
  logic [1:0]              unused_addr_bits;

  assign req_tag          = instr_addr_i[31:OFF+2];
  assign req_word         = instr_addr_i[OFF+1:2];
  assign unused_addr_bits = instr_addr_i[1:0];

  // Tag comparators, one per line.
  for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_hit
    assign line_hit[gi] = valid_reg[gi] & (tag_mem[gi] == req_tag);
  end

  // At most one line can match, so a plain encoder is enough.
  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (line_hit[i]) hit_idx = LIDX_W'(i);
    end
  end

  assign hit     = |line_hit;
  assign rd_word = data_mem[{hit_idx, req_word}];
  assign is_idle = (state_reg == IDLE);

  // A line whose refill just ended in error is invalid, but it still earns
  // exactly one error response if it is requested in the very first IDLE cycle.
  assign err_hit      = err_pending_reg & (refill_tag_reg == req_tag);
  assign gnt_hit      = is_idle & instr_req_i & ~flush_i & hit;
  assign gnt_err      = is_idle & instr_req_i & ~flush_i & ~hit & err_hit;
  assign start_refill = is_idle & instr_req_i & ~flush_i & ~hit & ~err_hit;
  assign instr_gnt_o  = gnt_hit | gnt_err;

  assign wait_word     = (state_reg == REFILL_WAIT) & mem_rvalid_i;
  assign last_word     = (cnt_reg == OFF'(LINE_WORDS - 1));
  assign line_err_next = line_err_reg | mem_err_i;

  // The next word is requested in the same cycle the previous one returns,
  // so in REFILL_WAIT the address already points at cnt+1.
  assign mem_req_o  = (state_reg == REFILL_REQ) | (wait_word & ~last_word);
  assign word_sel   = (state_reg == REFILL_WAIT) ? cnt_reg + 1'b1 : cnt_reg;
  assign mem_addr_o = mem_req_o ? {refill_tag_reg, word_sel, 2'b00} : 32'h0;

  assign instr_rvalid_o = rvalid_reg;
  assign instr_rdata_o  = rdata_reg;
  assign instr_err_o    = err_reg;
  assign busy_o         = ~is_idle | rvalid_reg;

  // Line storage: data and tags need no reset, validity lives in valid_reg.
  always_ff @(posedge clk) begin
    if (rst_n && wait_word) begin
      data_mem[{victim_reg, cnt_reg}] <= mem_rdata_i;
      if (last_word) tag_mem[victim_reg] <= refill_tag_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      valid_reg         <= '0;
      cnt_reg           <= '0;
      ptr_reg           <= '0;
      victim_reg        <= '0;
      refill_tag_reg    <= '0;
      line_err_reg      <= 1'b0;
      flush_pending_reg <= 1'b0;
      err_pending_reg   <= 1'b0;
      rvalid_reg        <= 1'b0;
      err_reg           <= 1'b0;
      rdata_reg         <= 32'h0;
    end else begin
      rvalid_reg      <= instr_gnt_o;
      rdata_reg       <= gnt_hit ? rd_word : 32'h0;
      err_reg         <= gnt_err;
      err_pending_reg <= 1'b0;
      if (flush_i) valid_reg <= '0;

      case (state_reg)
        IDLE: begin
          flush_pending_reg <= 1'b0;
          if (start_refill) begin
            refill_tag_reg     <= req_tag;
            victim_reg         <= ptr_reg;
            valid_reg[ptr_reg] <= 1'b0;
            cnt_reg            <= '0;
            line_err_reg       <= 1'b0;
            state_reg          <= REFILL_REQ;
          end
        end
        REFILL_REQ: begin
          if (flush_i) flush_pending_reg <= 1'b1;
          if (mem_gnt_i) state_reg <= REFILL_WAIT;
        end
        REFILL_WAIT: begin
          if (flush_i) flush_pending_reg <= 1'b1;
          if (mem_rvalid_i) begin
            line_err_reg <= line_err_next;
            if (!last_word) begin
              cnt_reg   <= cnt_reg + 1'b1;
              state_reg <= mem_gnt_i ? REFILL_WAIT : REFILL_REQ;
            end else begin
              // A flush seen at any point of the refill leaves the line invalid.
              valid_reg[victim_reg] <= ~line_err_next & ~flush_pending_reg & ~flush_i;
              ptr_reg               <= ptr_reg + 1'b1;
              cnt_reg               <= '0;
              err_pending_reg       <= line_err_next;
              state_reg             <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_instr_line_buffer.sv
// tb_riscv_instr_line_buffer
// Self-checking bench for riscv_instr_line_buffer: a cycle table for the cold
// miss and sequential hits, hand-written corner sequences, and a randomized
// run, all watched by a line-level reference model (set of cached line
// addresses, pending refill, expected memory request queue).
module tb_riscv_instr_line_buffer;

  localparam int NUM_LINES  = 2;
  localparam int LINE_WORDS = 4;
  localparam logic [31:0] LINE_BYTES = 32'(LINE_WORDS * 4);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;
  logic        flush_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;
  logic        busy_o;

  always #5 clk = ~clk;

  riscv_instr_line_buffer #(.NUM_LINES(NUM_LINES), .LINE_WORDS(LINE_WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .flush_i(flush_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .busy_o(busy_o)
  );

  int          n_chk;
  int          n_err;
  bit          rst_drive;
  bit          rand_gnt;
  logic [31:0] err_addr;
  bit          pend_v;
  logic [31:0] pend_a;
  logic [31:0] acc_q[$];

  logic        s_gnt, s_rvalid, s_err, s_mem_req, s_busy;
  logic [31:0] s_rdata, s_mem_addr;

  // Reference model state
  logic [31:0] m_tag[NUM_LINES];
  bit          m_val[NUM_LINES];
  int          m_ptr;
  bit          m_ref;
  int          m_victim;
  logic [31:0] m_base;
  int          m_got;
  bit          m_lerr, m_fpend;
  logic [31:0] m_exp_q[$];
  bit          m_errok;
  logic [31:0] m_errbase;
  bit          p_gnt, p_err;
  logic [31:0] p_addr;

  typedef struct {
    bit          req;
    logic [31:0] addr;
    bit          flush;
    bit          gnt;
    bit          rvalid;
    logic [31:0] rdata;
    bit          mem_req;
    logic [31:0] mem_addr;
    bit          busy;
  } vec_t;
  vec_t vecs[12];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) + 32'h60;
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'h1000 + 32'($urandom_range(0, 4)) * 16 + 32'($urandom_range(0, 3)) * 4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_LINES; i++) begin
      m_val[i] = 1'b0;
      m_tag[i] = 32'h0;
    end
    m_ptr = 0; m_ref = 1'b0; m_victim = 0; m_base = 32'h0; m_got = 0;
    m_lerr = 1'b0; m_fpend = 1'b0; m_exp_q.delete();
    m_errok = 1'b0; m_errbase = 32'h0;
    p_gnt = 1'b0; p_err = 1'b0; p_addr = 32'h0;
  endtask

  task automatic model_cycle();
    logic [31:0] base;
    bit hit, eg;
    base = instr_addr_i & ~(LINE_BYTES - 1);
    chk("rvalid", s_rvalid, p_gnt);
    if (p_gnt) begin
      chk("rdata", s_rdata, p_err ? 32'h0 : mem_word(p_addr));
      chk("err", s_err, p_err);
    end
    chk("busy", s_busy, m_ref | p_gnt);
    if (!m_ref) begin
      hit = 1'b0;
      for (int i = 0; i < NUM_LINES; i++)
        if (m_val[i] && m_tag[i] == base) hit = 1'b1;
      eg = instr_req_i && !flush_i && (hit || (m_errok && m_errbase == base));
      chk("gnt", s_gnt, eg);
      chk("mem_req_idle", s_mem_req, 0);
      p_gnt = eg; p_err = eg && !hit; p_addr = instr_addr_i & ~32'h3;
      m_errok = 1'b0;
      if (flush_i)
        for (int i = 0; i < NUM_LINES; i++) m_val[i] = 1'b0;
      if (instr_req_i && !flush_i && !eg) begin
        m_ref = 1'b1; m_victim = m_ptr; m_val[m_ptr] = 1'b0; m_base = base;
        m_got = 0; m_lerr = 1'b0; m_fpend = 1'b0;
        m_exp_q.delete();
        for (int i = 0; i < LINE_WORDS; i++) m_exp_q.push_back(base + 32'(i * 4));
      end
    end else begin
      chk("gnt_refill", s_gnt, 0);
      p_gnt = 1'b0; p_err = 1'b0;
      if (s_mem_req) begin
        if (m_exp_q.size() == 0) chk("mem_req_extra", s_mem_req, 0);
        else begin
          chk("mem_addr", s_mem_addr, m_exp_q[0]);
          if (mem_gnt_i) void'(m_exp_q.pop_front());
        end
      end
      if (flush_i) begin
        for (int i = 0; i < NUM_LINES; i++) m_val[i] = 1'b0;
        m_fpend = 1'b1;
      end
      if (mem_rvalid_i) begin
        m_got++;
        m_lerr = m_lerr | mem_err_i;
        if (m_got == LINE_WORDS) begin
          m_tag[m_victim] = m_base;
          m_val[m_victim] = !m_lerr && !m_fpend;
          m_ptr = (m_ptr + 1) % NUM_LINES;
          m_ref = 1'b0;
          m_errok = m_lerr;
          m_errbase = m_base;
        end
      end
    end
  endtask

  // One clock cycle: drive at the falling edge, sample 1 ns later, then let
  // the memory model record any accepted request at the rising edge.
  task automatic step(input bit req, input logic [31:0] addr, input bit flush);
    @(negedge clk);
    rst_n        = rst_drive;
    instr_req_i  = req;
    instr_addr_i = addr;
    flush_i      = flush;
    mem_rvalid_i = pend_v;
    mem_rdata_i  = pend_v ? mem_word(pend_a) : 32'h0;
    mem_err_i    = pend_v && (pend_a == err_addr);
    mem_gnt_i    = rand_gnt ? ($urandom_range(0, 3) != 0) : 1'b1;
    #1;
    s_gnt = instr_gnt_o; s_rvalid = instr_rvalid_o; s_rdata = instr_rdata_o;
    s_err = instr_err_o; s_mem_req = mem_req_o; s_mem_addr = mem_addr_o; s_busy = busy_o;
    if (rst_drive) model_cycle();
    else model_reset();
    @(posedge clk);
    if (!rst_drive) pend_v = 1'b0;
    else begin
      pend_v = s_mem_req && mem_gnt_i;
      pend_a = s_mem_addr;
      if (pend_v) acc_q.push_back(s_mem_addr);
    end
  endtask

  task automatic do_reset();
    rst_drive = 1'b0;
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    rst_drive = 1'b1;
    acc_q.delete();
  endtask

  task automatic fetch(input logic [31:0] a);
    for (int i = 0; i < 100; i++) begin
      step(1'b1, a, 1'b0);
      if (s_gnt) break;
    end
    chk("fetch_gnt", s_gnt, 1);
    step(1'b0, 32'h0, 1'b0);
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_gnt"}, s_gnt, 0);
    chk({pfx, "_rvalid"}, s_rvalid, 0);
    chk({pfx, "_rdata"}, s_rdata, 0);
    chk({pfx, "_err"}, s_err, 0);
    chk({pfx, "_mem_req"}, s_mem_req, 0);
    chk({pfx, "_mem_addr"}, s_mem_addr, 0);
    chk({pfx, "_busy"}, s_busy, 0);
  endtask

  initial begin
    logic [31:0] cur_addr;
    bit          cur_req;
    logic [31:0] exp_a;

    rst_n = 1'b0; instr_req_i = 1'b0; instr_addr_i = 32'h0; flush_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0; mem_err_i = 1'b0;
    n_chk = 0; n_err = 0; rst_drive = 1'b0; rand_gnt = 1'b0;
    err_addr = 32'hFFFF_FFFF; pend_v = 1'b0; pend_a = 32'h0;
    model_reset();

    //            req addr       fl gnt rv rdata  mreq maddr      busy
    vecs[0]  = '{1, 32'h100, 0, 0, 0, 32'h0,  0, 32'h0,   0};
    vecs[1]  = '{1, 32'h100, 0, 0, 0, 32'h0,  1, 32'h100, 1};
    vecs[2]  = '{1, 32'h100, 0, 0, 0, 32'h0,  1, 32'h104, 1};
    vecs[3]  = '{1, 32'h100, 0, 0, 0, 32'h0,  1, 32'h108, 1};
    vecs[4]  = '{1, 32'h100, 0, 0, 0, 32'h0,  1, 32'h10C, 1};
    vecs[5]  = '{1, 32'h100, 0, 0, 0, 32'h0,  0, 32'h0,   1};
    vecs[6]  = '{1, 32'h100, 0, 1, 0, 32'h0,  0, 32'h0,   0};
    vecs[7]  = '{1, 32'h104, 0, 1, 1, 32'hA0, 0, 32'h0,   1};
    vecs[8]  = '{1, 32'h108, 0, 1, 1, 32'hA1, 0, 32'h0,   1};
    vecs[9]  = '{1, 32'h10C, 0, 1, 1, 32'hA2, 0, 32'h0,   1};
    vecs[10] = '{0, 32'h0,   0, 0, 1, 32'hA3, 0, 32'h0,   1};
    vecs[11] = '{0, 32'h0,   0, 0, 0, 32'h0,  0, 32'h0,   0};

    // Reset state
    do_reset();
    step(1'b0, 32'h0, 1'b0);
    chk_zero("reset");

    // Cold miss and sequential hits
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].req, vecs[i].addr, vecs[i].flush);
      chk($sformatf("vec%0d_gnt", i), s_gnt, vecs[i].gnt);
      chk($sformatf("vec%0d_rvalid", i), s_rvalid, vecs[i].rvalid);
      if (vecs[i].rvalid) chk($sformatf("vec%0d_rdata", i), s_rdata, vecs[i].rdata);
      chk($sformatf("vec%0d_mem_req", i), s_mem_req, vecs[i].mem_req);
      if (vecs[i].mem_req) chk($sformatf("vec%0d_mem_addr", i), s_mem_addr, vecs[i].mem_addr);
      chk($sformatf("vec%0d_busy", i), s_busy, vecs[i].busy);
    end

    // Round-robin replacement: 0x300 evicts 0x100, 0x200 survives
    do_reset();
    fetch(32'h100); fetch(32'h200); fetch(32'h300);
    step(1'b1, 32'h204, 1'b0);
    chk("repl_hit_204", s_gnt, 1);
    step(1'b0, 32'h0, 1'b0);
    chk("repl_rdata_204", s_rdata, mem_word(32'h204));
    step(1'b1, 32'h100, 1'b0);
    chk("repl_miss_100", s_gnt, 0);
    fetch(32'h100);

    // Address change during a refill
    do_reset();
    step(1'b1, 32'h100, 1'b0);
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 32'h400, 1'b0);
      if (s_gnt) break;
    end
    chk("chg_gnt", s_gnt, 1);
    chk("chg_nreq", acc_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      exp_a = (i < 4) ? 32'h100 + 32'(i * 4) : 32'h400 + 32'((i - 4) * 4);
      if (i < acc_q.size()) chk($sformatf("chg_addr%0d", i), acc_q[i], exp_a);
    end
    step(1'b0, 32'h0, 1'b0);
    chk("chg_rdata", s_rdata, mem_word(32'h400));

    // Flush during a refill, then flush with a simultaneous hit
    do_reset();
    step(1'b1, 32'h100, 1'b0);
    for (int i = 0; i < 50; i++) begin
      if (acc_q.size() >= 3) break;
      step(1'b0, 32'h0, 1'b0);
    end
    step(1'b0, 32'h0, 1'b1);
    chk("fl_busy", s_busy, 1);
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 32'h0, 1'b0);
      if (!s_busy) break;
    end
    chk("fl_drain", s_busy, 0);
    step(1'b1, 32'h100, 1'b0);
    chk("fl_line_invalid", s_gnt, 0);
    fetch(32'h100);
    chk("fl_refill_rdata", s_rdata, mem_word(32'h100));
    step(1'b1, 32'h100, 1'b1);
    chk("fl_hit_gnt", s_gnt, 0);
    step(1'b1, 32'h100, 1'b0);
    chk("fl_after_flush", s_gnt, 0);
    fetch(32'h100);

    // Error on word 1: one error response, then a fresh refill
    do_reset();
    err_addr = 32'h104;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 32'h100, 1'b0);
      if (s_gnt) break;
    end
    chk("err_gnt", s_gnt, 1);
    step(1'b0, 32'h0, 1'b0);
    chk("err_rvalid", s_rvalid, 1);
    chk("err_flag", s_err, 1);
    chk("err_rdata", s_rdata, 0);
    err_addr = 32'hFFFF_FFFF;
    step(1'b1, 32'h100, 1'b0);
    chk("err_rerefill", s_gnt, 0);
    fetch(32'h100);
    chk("err_clean_rdata", s_rdata, mem_word(32'h100));
    chk("err_clean_flag", s_err, 0);

    // Reset in the middle of a refill
    do_reset();
    fetch(32'h200);
    step(1'b1, 32'h100, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    rst_drive = 1'b0;
    step(1'b0, 32'h0, 1'b0);
    rst_drive = 1'b1;
    step(1'b0, 32'h0, 1'b0);
    chk_zero("midrst");
    step(1'b1, 32'h200, 1'b0);
    chk("rst_lines_invalid", s_gnt, 0);
    fetch(32'h200);

    // Randomized traffic against the model
    rand_gnt = 1'b1;
    do_reset();
    cur_addr = rand_addr();
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) err_addr = ($urandom_range(0, 1) != 0) ? rand_addr() : 32'hFFFF_FFFF;
      cur_req = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0) cur_addr = rand_addr();
      step(cur_req, cur_addr, ($urandom_range(0, 49) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
